// File: rtl/dm_pkg.sv
// Shared debug-module types: state encoding and AXI response codes for the
// system-bus-access AXI4-Lite bridge.
package dm_pkg;

  typedef enum logic [2:0] {
    AxIdle,
    AxWrite,
    AxWaitB,
    AxRead,
    AxWaitR,
    AxResp
  } sba_axil_state_e;

  localparam logic [1:0] AxiRespOkay = 2'b00;

endpackage

// File: rtl/dm_sba_axil_bridge.sv
// Converts each SBA req/gnt/r_valid access into exactly one AXI4-Lite transaction.
// Optional response timeout with late-beat sinking: define DM_SBA_AXIL_TIMEOUT_EN.
module dm_sba_axil_bridge
  import dm_pkg::*;
#(
  parameter int unsigned BusWidth      = 32,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  dmactive_i,
  input  logic                  req_i,
  input  logic [BusWidth-1:0]   add_i,
  input  logic                  we_i,
  input  logic [BusWidth-1:0]   wdata_i,
  input  logic [BusWidth/8-1:0] be_i,
  output logic                  gnt_o,
  output logic                  r_valid_o,
  output logic [BusWidth-1:0]   r_rdata_o,
  output logic                  r_err_o,
  output logic [BusWidth-1:0]   m_awaddr_o,
  output logic [2:0]            m_awprot_o,
  output logic                  m_awvalid_o,
  input  logic                  m_awready_i,
  output logic [BusWidth-1:0]   m_wdata_o,
  output logic [BusWidth/8-1:0] m_wstrb_o,
  output logic                  m_wvalid_o,
  input  logic                  m_wready_i,
  input  logic [1:0]            m_bresp_i,
  input  logic                  m_bvalid_i,
  output logic                  m_bready_o,
  output logic [BusWidth-1:0]   m_araddr_o,
  output logic [2:0]            m_arprot_o,
  output logic                  m_arvalid_o,
  input  logic                  m_arready_i,
  input  logic [BusWidth-1:0]   m_rdata_i,
  input  logic [1:0]            m_rresp_i,
  input  logic                  m_rvalid_i,
  output logic                  m_rready_o
);

  sba_axil_state_e       r_state, w_state_nxt;
  logic [BusWidth-1:0]   r_addr, r_wdata, r_rdata, w_rdata_nxt;
  logic [BusWidth/8-1:0] r_be;
  logic                  r_aw_done, r_w_done, r_err, r_quiet;
  logic                  w_aw_done_nxt, w_w_done_nxt, w_err_nxt;
  logic                  w_grant, w_busy, w_block;

  assign w_busy  = (r_state == AxWrite) || (r_state == AxWaitB) ||
                   (r_state == AxRead)  || (r_state == AxWaitR);
  assign w_grant = req_i && (r_state == AxIdle) && !w_block;
  assign gnt_o   = w_grant;

  assign m_awaddr_o = r_addr;
  assign m_araddr_o = r_addr;
  assign m_wdata_o  = r_wdata;
  assign m_wstrb_o  = r_be;
  assign m_awprot_o = 3'b000;
  assign m_arprot_o = 3'b000;
  assign r_rdata_o  = r_rdata;
  assign r_err_o    = r_err;

`ifdef DM_SBA_AXIL_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

  logic [CntW-1:0] r_cnt;
  logic            r_pend, r_pend_we;
  logic            w_rsp_done, w_tmo_fire, w_sink;

  assign w_rsp_done = ((r_state == AxWaitB) && m_bvalid_i) ||
                      ((r_state == AxWaitR) && m_rvalid_i);
  // A real response arriving on the last allowed cycle wins over the timeout.
  assign w_tmo_fire = w_busy && (r_cnt == CntW'(TimeoutCycles - 1)) && !w_rsp_done;
  assign w_sink     = (r_state == AxIdle) && r_pend &&
                      (r_pend_we ? m_bvalid_i : m_rvalid_i);
  assign w_block    = r_pend;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt     <= '0;
      r_pend    <= 1'b0;
      r_pend_we <= 1'b0;
    end else begin
      r_cnt <= w_busy ? r_cnt + 1'b1 : '0;
      if (w_tmo_fire) begin
        r_pend    <= 1'b1;
        r_pend_we <= (r_state == AxWrite) || (r_state == AxWaitB);
      end else if (w_sink) begin
        r_pend <= 1'b0;
      end
    end
  end
`else
  assign w_block = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_aw_done_nxt = r_aw_done;
    w_w_done_nxt  = r_w_done;
    w_rdata_nxt   = r_rdata;
    w_err_nxt     = r_err;
    m_awvalid_o   = 1'b0;
    m_wvalid_o    = 1'b0;
    m_bready_o    = 1'b0;
    m_arvalid_o   = 1'b0;
    m_rready_o    = 1'b0;
    r_valid_o     = 1'b0;
    case (r_state)
      AxIdle: begin
        if (w_grant) begin
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
          w_state_nxt   = we_i ? AxWrite : AxRead;
        end
      end
      AxWrite: begin
        // AW and W retire independently; valid is held only until its own handshake.
        m_awvalid_o   = ~r_aw_done;
        m_wvalid_o    = ~r_w_done;
        w_aw_done_nxt = r_aw_done | m_awready_i;
        w_w_done_nxt  = r_w_done | m_wready_i;
        if (w_aw_done_nxt && w_w_done_nxt) w_state_nxt = AxWaitB;
      end
      AxWaitB: begin
        m_bready_o = 1'b1;
        if (m_bvalid_i) begin
          w_rdata_nxt = '0;
          w_err_nxt   = (m_bresp_i != AxiRespOkay);
          w_state_nxt = AxResp;
        end
      end
      AxRead: begin
        m_arvalid_o = 1'b1;
        if (m_arready_i) w_state_nxt = AxWaitR;
      end
      AxWaitR: begin
        m_rready_o = 1'b1;
        if (m_rvalid_i) begin
          w_rdata_nxt = m_rdata_i;
          w_err_nxt   = (m_rresp_i != AxiRespOkay);
          w_state_nxt = AxResp;
        end
      end
      AxResp: begin
        r_valid_o   = dmactive_i && !r_quiet;
        w_state_nxt = AxIdle;
      end
      default: w_state_nxt = AxIdle;
    endcase
`ifdef DM_SBA_AXIL_TIMEOUT_EN
    if (w_tmo_fire) begin
      w_state_nxt = AxResp;
      w_rdata_nxt = '0;
      w_err_nxt   = 1'b1;
    end
    if ((r_state == AxIdle) && r_pend) begin
      m_bready_o = r_pend_we;
      m_rready_o = ~r_pend_we;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= AxIdle;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_quiet   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
      r_rdata   <= w_rdata_nxt;
      r_err     <= w_err_nxt;
      if (w_grant) begin
        r_addr  <= add_i;
        r_wdata <= wdata_i;
        r_be    <= be_i;
      end
      // Any dmactive_i drop while the bus access is in flight silences its completion.
      if (!w_busy) r_quiet <= 1'b0;
      else if (!dmactive_i) r_quiet <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dm_sba_axil_bridge.sv
// Self-checking bench for dm_sba_axil_bridge: directed steps plus randomized
// accesses against a responsive AXI4-Lite slave with configurable delays.
module tb_dm_sba_axil_bridge;

  logic        clk = 1'b0;
  logic        rst_n, dmactive, req, we;
  logic [31:0] add, wdata;
  logic [3:0]  be;
  logic        gnt_o, r_valid_o, r_err_o;
  logic [31:0] r_rdata_o;
  logic [31:0] m_awaddr_o, m_wdata_o, m_araddr_o;
  logic [2:0]  m_awprot_o, m_arprot_o;
  logic [3:0]  m_wstrb_o;
  logic        m_awvalid_o, m_wvalid_o, m_bready_o, m_arvalid_o, m_rready_o;

  logic        awready = 1'b0, wready = 1'b0, arready = 1'b0;
  logic        bvalid = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = '0;

  int          cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0, cfg_ar_dly = 0, cfg_r_dly = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = '0;
  int          r_inject = 0;
  bit          mon_en = 1'b1;

  int          n_assert = 0, n_fail = 0;

  always #5 clk = ~clk;

  dm_sba_axil_bridge #(.BusWidth(32), .TimeoutCycles(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .dmactive_i(dmactive),
    .req_i(req), .add_i(add), .we_i(we), .wdata_i(wdata), .be_i(be),
    .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o), .r_err_o(r_err_o),
    .m_awaddr_o(m_awaddr_o), .m_awprot_o(m_awprot_o), .m_awvalid_o(m_awvalid_o),
    .m_awready_i(awready),
    .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o), .m_wvalid_o(m_wvalid_o),
    .m_wready_i(wready),
    .m_bresp_i(bresp), .m_bvalid_i(bvalid), .m_bready_o(m_bready_o),
    .m_araddr_o(m_araddr_o), .m_arprot_o(m_arprot_o), .m_arvalid_o(m_arvalid_o),
    .m_arready_i(arready),
    .m_rdata_i(rdata), .m_rresp_i(rresp), .m_rvalid_i(rvalid), .m_rready_o(m_rready_o)
  );

  // Bus monitor: handshake counts, last beat contents, valid run lengths, protocol rules
  int          cyc = 0, aw_total = 0, w_total = 0, b_total = 0, ar_total = 0, r_total = 0;
  int          rv_total = 0, viol = 0;
  int          aw_run = 0, w_run = 0, ar_run = 0, aw_len = 0, w_len = 0, ar_len = 0;
  logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0, p_awaddr = '0, p_araddr = '0;
  logic [3:0]  last_wstrb = '0;
  logic        p_aw = 1'b0, p_awr = 1'b0, p_w = 1'b0, p_wr = 1'b0, p_ar = 1'b0, p_arr = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_awvalid_o && awready) begin
      aw_total <= aw_total + 1; last_awaddr <= m_awaddr_o; aw_len <= aw_run + 1;
    end
    if (m_wvalid_o && wready) begin
      w_total <= w_total + 1; last_wdata <= m_wdata_o; last_wstrb <= m_wstrb_o; w_len <= w_run + 1;
    end
    if (m_arvalid_o && arready) begin
      ar_total <= ar_total + 1; last_araddr <= m_araddr_o; ar_len <= ar_run + 1;
    end
    aw_run <= (m_awvalid_o && !awready) ? aw_run + 1 : 0;
    w_run  <= (m_wvalid_o && !wready) ? w_run + 1 : 0;
    ar_run <= (m_arvalid_o && !arready) ? ar_run + 1 : 0;
    if (bvalid && m_bready_o) b_total <= b_total + 1;
    if (rvalid && m_rready_o) r_total <= r_total + 1;
    if (r_valid_o) rv_total <= rv_total + 1;
    if (mon_en && rst_n) begin
      if ((p_aw && !p_awr && (!m_awvalid_o || m_awaddr_o != p_awaddr)) ||
          (p_w && !p_wr && !m_wvalid_o) ||
          (p_ar && !p_arr && (!m_arvalid_o || m_araddr_o != p_araddr)))
        viol <= viol + 1;
    end
    p_aw <= m_awvalid_o; p_awr <= awready; p_awaddr <= m_awaddr_o;
    p_w  <= m_wvalid_o;  p_wr  <= wready;
    p_ar <= m_arvalid_o; p_arr <= arready; p_araddr <= m_araddr_o;
  end

  // AXI4-Lite slave: readies after cfg delays, one B per AW+W pair, one R per AR (or injection)
  int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0, b_goal = 0, r_goal = 0;

  always @(negedge clk) begin
    if (m_awvalid_o) begin awready <= (aw_wait >= cfg_aw_dly); aw_wait <= aw_wait + 1; end
    else begin awready <= 1'b0; aw_wait <= 0; end
    if (m_wvalid_o) begin wready <= (w_wait >= cfg_w_dly); w_wait <= w_wait + 1; end
    else begin wready <= 1'b0; w_wait <= 0; end
    if (m_arvalid_o) begin arready <= (ar_wait >= cfg_ar_dly); ar_wait <= ar_wait + 1; end
    else begin arready <= 1'b0; ar_wait <= 0; end
    if (bvalid) begin
      if (b_total == b_goal) bvalid <= 1'b0;
    end else if (((aw_total < w_total) ? aw_total : w_total) > b_total) begin
      if (b_wait >= cfg_b_dly) begin
        bvalid <= 1'b1; bresp <= cfg_bresp; b_goal <= b_total + 1; b_wait <= 0;
      end else b_wait <= b_wait + 1;
    end
    if (rvalid) begin
      if (r_total == r_goal) rvalid <= 1'b0;
    end else if (ar_total + r_inject > r_total) begin
      if (r_wait >= cfg_r_dly) begin
        rvalid <= 1'b1; rresp <= cfg_rresp; rdata <= cfg_rdata; r_goal <= r_total + 1; r_wait <= 0;
      end else r_wait <= r_wait + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full access; expectations come from the slave configuration and the bridge rules.
  task automatic run_txn(input string nm, input bit twe, input logic [31:0] taddr,
                         input logic [31:0] twdata, input logic [3:0] tbe, input bit poke);
    int c0, lat, aw0, w0, b0, ar0, r0, rv0, exp_lat;
    bit got;
    logic [31:0] exp_rd;
    logic exp_err;
    @(negedge clk);
    aw0 = aw_total; w0 = w_total; b0 = b_total; ar0 = ar_total; r0 = r_total; rv0 = rv_total;
    exp_rd  = twe ? 32'h0 : cfg_rdata;
    exp_err = twe ? (cfg_bresp != 2'b00) : (cfg_rresp != 2'b00);
    exp_lat = twe ? 3 + ((cfg_aw_dly > cfg_w_dly) ? cfg_aw_dly : cfg_w_dly) + cfg_b_dly
                  : 3 + cfg_ar_dly + cfg_r_dly;
    req = 1'b1; we = twe; add = taddr; wdata = twdata; be = tbe;
    #1;
    chk({nm, "_gnt"}, gnt_o, 1);
    c0 = cyc;
    @(negedge clk);
    req = 1'b0; we = $urandom; add = $urandom; wdata = $urandom; be = 4'($urandom);
    got = 1'b0; lat = 0;
    for (int k = 0; k < 200; k++) begin
      if (r_valid_o) begin got = 1'b1; lat = cyc - c0; break; end
      if (poke && k == 0) begin
        req = 1'b1; #1;
        chk({nm, "_busy_nogrant"}, gnt_o, 0);
        req = 1'b0;
      end
      @(negedge clk);
    end
    chk({nm, "_done"}, got, 1);
    if (got) begin
      chk({nm, "_latency"}, lat, exp_lat);
      chk({nm, "_rdata"}, r_rdata_o, exp_rd);
      chk({nm, "_err"}, r_err_o, exp_err);
      @(negedge clk);
      chk({nm, "_pulse1"}, r_valid_o, 0);
      chk({nm, "_rdata_hold"}, r_rdata_o, exp_rd);
    end
    chk({nm, "_rv_count"}, rv_total - rv0, 1);
    if (twe) begin
      chk({nm, "_aw_count"}, aw_total - aw0, 1);
      chk({nm, "_w_count"}, w_total - w0, 1);
      chk({nm, "_b_count"}, b_total - b0, 1);
      chk({nm, "_awaddr"}, last_awaddr, taddr);
      chk({nm, "_wdata"}, last_wdata, twdata);
      chk({nm, "_wstrb"}, last_wstrb, tbe);
      chk({nm, "_aw_len"}, aw_len, cfg_aw_dly + 1);
      chk({nm, "_w_len"}, w_len, cfg_w_dly + 1);
    end else begin
      chk({nm, "_ar_count"}, ar_total - ar0, 1);
      chk({nm, "_r_count"}, r_total - r0, 1);
      chk({nm, "_araddr"}, last_araddr, taddr);
      chk({nm, "_ar_len"}, ar_len, cfg_ar_dly + 1);
    end
    chk({nm, "_protocol"}, viol, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, rv0, r0, aw0;
    bit got;
    rst_n = 1'b1; dmactive = 1'b1; req = 1'b0; we = 1'b0; add = '0; wdata = '0; be = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_awvalid", m_awvalid_o, 0);
    chk("rst_wvalid", m_wvalid_o, 0);
    chk("rst_arvalid", m_arvalid_o, 0);
    chk("rst_bready", m_bready_o, 0);
    chk("rst_rready", m_rready_o, 0);
    chk("rst_rvalid", r_valid_o, 0);
    chk("rst_rerr", r_err_o, 0);
    chk("rst_rdata", r_rdata_o, 0);
    chk("rst_awaddr", m_awaddr_o, 0);
    chk("rst_wdata", m_wdata_o, 0);
    chk("rst_wstrb", m_wstrb_o, 0);
    chk("rst_prot", {m_awprot_o, m_arprot_o}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_txn("wr_basic", 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0);

    cfg_ar_dly = 5; cfg_rdata = 32'h1234_5678; cfg_rresp = 2'b00;
    run_txn("rd_slow_ar", 1'b0, 32'h1000_0004, 32'h0, 4'h0, 1'b0);
    chk("rd_slow_ar_hold6", ar_len, 6);

    cfg_ar_dly = 0; cfg_aw_dly = 4; cfg_w_dly = 0;
    run_txn("wr_w_first", 1'b1, 32'h2000_0102, 32'h00AB_0000, 4'h4, 1'b1);

    cfg_aw_dly = 0; cfg_rresp = 2'b10; cfg_rdata = 32'hAAAA_5555;
    run_txn("rd_slverr", 1'b0, 32'h3000_0008, 32'h0, 4'h0, 1'b0);

    cfg_bresp = 2'b11;
    run_txn("wr_decerr", 1'b1, 32'h4000_0000, 32'h5A5A_A5A5, 4'h3, 1'b0);
    cfg_bresp = 2'b00; cfg_rresp = 2'b00;

    // dmactive_i dropped while waiting for R: handshake completes, no completion pulse
    cfg_r_dly = 4; cfg_rdata = 32'hCAFE_0001;
    @(negedge clk);
    rv0 = rv_total; r0 = r_total;
    req = 1'b1; we = 1'b0; add = 32'h5000_0000; #1;
    chk("dm_gnt", gnt_o, 1);
    @(negedge clk); req = 1'b0;
    @(negedge clk); dmactive = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (r_total > r0) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("dm_r_handshake", got, 1);
    repeat (3) @(negedge clk);
    chk("dm_no_pulse", rv_total - rv0, 0);
    chk("dm_protocol", viol, 0);
    dmactive = 1'b1; cfg_r_dly = 0; cfg_rdata = 32'h7777_1111;
    run_txn("dm_after", 1'b0, 32'h5000_0004, 32'h0, 4'h0, 1'b0);

    // Reset asserted while AW/W are outstanding
    cfg_aw_dly = 8; cfg_w_dly = 8;
    @(negedge clk);
    aw0 = aw_total;
    req = 1'b1; we = 1'b1; add = 32'h6000_0000; wdata = 32'h1; be = 4'hF; #1;
    chk("rstmid_gnt", gnt_o, 1);
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    chk("rstmid_awvalid_before", m_awvalid_o, 1);
    mon_en = 1'b0; rst_n = 1'b0; #1;
    chk("rstmid_awvalid", m_awvalid_o, 0);
    chk("rstmid_wvalid", m_wvalid_o, 0);
    chk("rstmid_rdata", r_rdata_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    chk("rstmid_no_aw", aw_total - aw0, 0);
    cfg_aw_dly = 0; cfg_w_dly = 0;

    for (int i = 0; i < 40; i++) begin
      cfg_aw_dly = $urandom_range(0, 4); cfg_w_dly = $urandom_range(0, 4);
      cfg_b_dly  = $urandom_range(0, 4); cfg_ar_dly = $urandom_range(0, 4);
      cfg_r_dly  = $urandom_range(0, 4);
      cfg_bresp  = 2'($urandom_range(0, 3)); cfg_rresp = 2'($urandom_range(0, 3));
      cfg_rdata  = $urandom;
      run_txn("rand", 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)), 1'b0);
    end
    cfg_aw_dly = 0; cfg_w_dly = 0; cfg_b_dly = 0; cfg_ar_dly = 0; cfg_r_dly = 0;
    cfg_bresp = 2'b00; cfg_rresp = 2'b00;

`ifdef DM_SBA_AXIL_TIMEOUT_EN
    // Slave never accepts AR: error after 16 cycles, late R sunk before next grant
    mon_en = 1'b0; cfg_ar_dly = 100000; cfg_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    rv0 = rv_total;
    req = 1'b1; we = 1'b0; add = 32'h7000_0000; #1;
    chk("tmo_gnt", gnt_o, 1);
    c0 = cyc;
    @(negedge clk); req = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (r_valid_o) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("tmo_done", got, 1);
    chk("tmo_latency", cyc - c0, 17);
    chk("tmo_err", r_err_o, 1);
    chk("tmo_rdata", r_rdata_o, 0);
    @(negedge clk);
    chk("tmo_arvalid_low", m_arvalid_o, 0);
    chk("tmo_sink_rready", m_rready_o, 1);
    req = 1'b1; #1;
    chk("tmo_pending_nogrant", gnt_o, 0);
    req = 1'b0;
    r0 = r_total; r_inject = 1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (r_total > r0) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("tmo_late_r_absorbed", got, 1);
    @(negedge clk);
    chk("tmo_sink_released", m_rready_o, 0);
    chk("tmo_one_pulse", rv_total - rv0, 1);
    cfg_ar_dly = 0; cfg_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    mon_en = 1'b1;
    run_txn("tmo_after", 1'b0, 32'h7000_0010, 32'h0, 4'h0, 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_sba_axil_bridge.md
Name: dm_sba_axil_bridge

Overview:
- Downstream neighbour of the debug-module system-bus-access FSM.
- Accepts its req/gnt/r_valid master protocol (`master_*` signals) and converts each access into exactly one AXI4-Lite transaction on the SoC interconnect.
- Returns read data, write completion and bus errors.
- One outstanding access at a time; the upstream FSM never issues a second request before completion.

Parameters:
- BusWidth, 32, data and address width (32 or 64).
- TimeoutCycles, 1024, response timeout in clk_i cycles; used only with DM_SBA_AXIL_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- dmactive_i  in  1  debug module active; low suppresses completion reporting
- req_i  in  1  access request from SBA FSM
- add_i  in  BusWidth  byte address
- we_i  in  1  1=write, 0=read
- wdata_i  in  BusWidth  write data
- be_i  in  BusWidth/8  byte enables
- gnt_o  out  1  request accepted
- r_valid_o  out  1  one-cycle completion pulse (read and write)
- r_rdata_o  out  BusWidth  read data, 0 for writes
- r_err_o  out  1  completion carries error, valid with r_valid_o
- m_awaddr_o  out  BusWidth; m_awprot_o  out  3; m_awvalid_o  out  1; m_awready_i  in  1
- m_wdata_o  out  BusWidth; m_wstrb_o  out  BusWidth/8; m_wvalid_o  out  1; m_wready_i  in  1
- m_bresp_i  in  2; m_bvalid_i  in  1; m_bready_o  out  1
- m_araddr_o  out  BusWidth; m_arprot_o  out  3; m_arvalid_o  out  1; m_arready_i  in  1
- m_rdata_i  in  BusWidth; m_rresp_i  in  2; m_rvalid_i  in  1; m_rready_o  out  1

Behaviour:
- Clock and reset: single clock clk_i; asynchronous active-low reset rst_ni.
- Reset values: state Idle; all AXI valid/ready outputs 0; r_valid_o=0, r_err_o=0, r_rdata_o=0; address/data/strobe registers 0.
- Prot: m_awprot_o = m_arprot_o = 3'b000, constant.
- Idle: gnt_o = req_i, combinational, asserted only in Idle.
  - On req_i, capture add_i, wdata_i and be_i into registers.
  - Next state is Write if we_i, else Read.
- Write:
  - m_awvalid_o and m_wvalid_o are both asserted on entry.
  - Each deasserts independently after its own handshake (valid&ready); AW and W may complete in any order or in the same cycle.
  - When both handshakes are done, go to WaitB.
  - Valids never drop before their handshake.
- WaitB: m_bready_o=1.
  - On m_bvalid_i, register err = (m_bresp_i != 2'b00) and rdata = 0, then go to Resp.
- Read:
  - m_arvalid_o=1 until m_arready_i, then go to WaitR.
- WaitR: m_rready_o=1.
  - On m_rvalid_i, register m_rdata_i and err = (m_rresp_i != 2'b00), then go to Resp.
  - On error, rdata is still passed through.
- Resp:
  - r_valid_o=1 for exactly one cycle, together with r_rdata_o and r_err_o; then go to Idle.
  - r_rdata_o holds its value until the next completion.
- Latency: req cycle (gnt) -> earliest r_valid_o is 3 cycles later when ready and resp are immediate (request, AW/W or AR, B or R, Resp).
- Strobes: m_wstrb_o = captured be_i unmodified. Address is passed unaligned; alignment is the upstream FSM's job.
- dmactive_i low mid-transaction:
  - AXI handshakes run to completion; protocol is never violated.
  - The Resp pulse is suppressed (r_valid_o stays 0).
  - dmactive_i low in Idle still grants requests; the upstream FSM is itself held idle.
- Reset mid-transaction: immediate return to Idle with all valids 0. The SoC is responsible for resetting the interconnect coherently.
- req_i outside Idle is ignored; no gnt is given.

Optional Feature:
- DM_SBA_AXIL_TIMEOUT_EN defined:
  - A counter of width $clog2(TimeoutCycles+1) counts cycles spent in Write, Read, WaitB and WaitR.
  - It clears on entry to Idle.
  - If it reaches TimeoutCycles, go to Resp with r_err_o=1 and r_rdata_o=0.
  - Valids are forced low; any late B/R response is then sunk: m_bready_o/m_rready_o are held 1 in Idle until one beat is absorbed, tracked by a pending flag.
  - New requests are not granted while the pending flag is set.
- Not defined: no counter, no pending flag; a non-responding slave hangs the bridge (and sbbusy) indefinitely.

Decomposition:
- dm_pkg gains:
  - typedef enum logic [2:0] sba_axil_state_e {AxIdle, AxWrite, AxWaitB, AxRead, AxWaitR, AxResp}.
  - localparam logic [1:0] AxiRespOkay = 2'b00.
- No sub-module; the FSM, capture registers and optional timeout counter live in one module.

Test Plan:
- Write: addr 0x8000_0010, wdata 0xDEAD_BEEF, be 4'hF, awready/wready/bvalid immediate with bresp 0 -> one AW and one W beat with those values; r_valid_o pulse 3 cycles after gnt with r_err_o=0.
- Read: addr 0x1000_0004, arready delayed 5 cycles, rdata 0x1234_5678, rresp 0 -> arvalid held stable 6 cycles; r_rdata_o=0x1234_5678, r_err_o=0.
- Write with W handshake 4 cycles before AW handshake -> wvalid drops after its handshake, awvalid persists, exactly one B accepted; byte write be 4'h4 -> wstrb 4'h4.
- Read with rresp 2'b10 (SLVERR), rdata 0xAAAA_5555 -> r_err_o=1, r_rdata_o=0xAAAA_5555.
- dmactive_i dropped during WaitR, then rvalid -> rready handshake completes, no r_valid_o; next request granted normally. Assert rst_ni low in the Write state -> awvalid/wvalid go 0 asynchronously.
- With DM_SBA_AXIL_TIMEOUT_EN, TimeoutCycles=16, read with no arready -> r_err_o=1 after 16 cycles in Read; a late rvalid is absorbed before the next gnt.
